// File: rtl/ce_mon_pkg.sv
// ce_mon_pkg: shared state encoding and default timing constants for the clock-enable period monitor.
package ce_mon_pkg;
  typedef enum logic [1:0] {ACQUIRE, LOCKING, LOCKED, FAULT} state_e;
  localparam int unsigned DEF_PERIOD = 65536;
  localparam int unsigned DEF_TOL = 2;
  localparam int unsigned DEF_LOCK_COUNT = 4;
  localparam int unsigned DEF_CNT_W = 17;
endpackage

// File: rtl/ce_interval_counter.sv
// ce_interval_counter: cycles since the last pulse, saturating at PERIOD+TOL with a one-shot timeout.
module ce_interval_counter import ce_mon_pkg::*; #(
  parameter int unsigned PERIOD = DEF_PERIOD,
  parameter int unsigned TOL = DEF_TOL,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             timeout_o
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(PERIOD + TOL);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // parking at LIMIT makes the timeout compare true only once per gap
  always_comb cnt_d = pulse_i ? '0 : (cnt_q == LIMIT ? cnt_q : cnt_q + 1'b1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign timeout_o = !pulse_i && (cnt_q == LIMIT - 1'b1);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ce_period_monitor.sv
// ce_period_monitor: checks a clk_en pulse stream against PERIOD+/-TOL and tracks lock/fault.
module ce_period_monitor import ce_mon_pkg::*; #(
  parameter int unsigned PERIOD = DEF_PERIOD,
  parameter int unsigned TOL = DEF_TOL,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en_in,
  input  logic             clr_fault,
  output logic             locked,
  output logic             fault,
  output logic             window_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] last_period,
  output logic [15:0]      pulse_count
);
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  state_e state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [CNT_W-1:0] cnt, interval, last_q, last_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic timeout, in_win, seen_q, werr_q, werr_d, terr_q, terr_d, locked_q, fault_q;
  ce_interval_counter #(.PERIOD(PERIOD), .TOL(TOL), .CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .pulse_i(clk_en_in), .cnt_o(cnt), .timeout_o(timeout)
  );
  assign interval = cnt + 1'b1;
  assign in_win = interval >= CNT_W'(PERIOD - TOL) && interval <= CNT_W'(PERIOD + TOL);
  always_comb begin
    state_d = state_q;
    good_d = good_q;
    werr_d = 1'b0;
    terr_d = 1'b0;
    unique case (state_q)
      ACQUIRE: if (clk_en_in) begin
        state_d = LOCKING;
        good_d = '0;
      end
      LOCKING: if (clk_en_in && in_win) begin
        good_d = good_q + 1'b1;
        if (good_d == GW'(LOCK_COUNT)) state_d = LOCKED;
      end else if (clk_en_in) begin
        werr_d = 1'b1;
        good_d = '0;
      end else if (timeout) begin
        terr_d = 1'b1;
        good_d = '0;
        state_d = ACQUIRE;
      end
      LOCKED: if ((clk_en_in && !in_win) || timeout) begin
        werr_d = clk_en_in;
        terr_d = !clk_en_in;
        state_d = FAULT;
      end
      FAULT: if (clr_fault) state_d = ACQUIRE;
      default: state_d = ACQUIRE;
    endcase
    last_d = (clk_en_in && seen_q) ? interval : last_q;
    pcnt_d = pcnt_q + 16'(clk_en_in);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACQUIRE;
      good_q <= '0;
      werr_q <= 1'b0;
      terr_q <= 1'b0;
      locked_q <= 1'b0;
      fault_q <= 1'b0;
      last_q <= '0;
      pcnt_q <= '0;
      seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q <= good_d;
      werr_q <= werr_d;
      terr_q <= terr_d;
      locked_q <= state_d == LOCKED;
      fault_q <= state_d == FAULT;
      last_q <= last_d;
      pcnt_q <= pcnt_d;
      seen_q <= seen_q | clk_en_in;
    end
  end
  assign locked = locked_q;
  assign fault = fault_q;
  assign window_err = werr_q;
  assign timeout_err = terr_q;
  assign last_period = last_q;
  assign pulse_count = pcnt_q;
endmodule

// File: doc/ce_period_monitor.md
CE_PERIOD_MONITOR -- requirements
Module: ce_period_monitor

Interface
REQ-001 SHALL have parameter PERIOD, default 65536: expected clk cycles between clk_en_in pulses.
REQ-002 SHALL have parameter TOL, default 2: allowed deviation in cycles, ±TOL.
REQ-003 SHALL have parameter LOCK_COUNT, default 4: consecutive in-window intervals needed to lock.
REQ-004 SHALL have parameter CNT_W, default 17: interval counter width; PERIOD+TOL+1 SHALL fit in CNT_W.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 clk_en_in  input  1  enable pulse stream under test, synchronous to clk.
REQ-008 clr_fault  input  1  clears FAULT state.
REQ-009 locked  output  1  high while in LOCKED.
REQ-010 fault  output  1  high while in FAULT.
REQ-011 window_err  output  1  one-cycle pulse: a pulse arrived outside the window.
REQ-012 timeout_err  output  1  one-cycle pulse: no pulse by PERIOD+TOL.
REQ-013 last_period  output  CNT_W  most recently measured interval.
REQ-014 pulse_count  output  16  total pulses seen since reset, wraps at 0xFFFF->0.

Function
REQ-015 Interval counter cnt SHALL load 0 on a clk_en_in=1 cycle, else increment; measured interval = cnt+1 at pulse; pulses every 65536 cycles SHALL measure 65536.
REQ-016 In-window SHALL mean PERIOD-TOL <= interval <= PERIOD+TOL.
REQ-017 Timeout SHALL occur in a cycle with clk_en_in=0 and cnt+1 == PERIOD+TOL; cnt SHALL then hold (saturate) until the next pulse; timeout fires once per gap.
REQ-018 States: ACQUIRE, LOCKING, LOCKED, FAULT; reset state ACQUIRE.
REQ-019 ACQUIRE: first pulse -> LOCKING, good_cnt=0; no interval check, no errors.
REQ-020 LOCKING: in-window pulse -> good_cnt+1; reaching LOCK_COUNT -> LOCKED. Out-of-window pulse -> window_err, good_cnt=0, stay. Timeout -> timeout_err, good_cnt=0, ACQUIRE.
REQ-021 LOCKED: in-window pulse stays; out-of-window pulse -> window_err, FAULT; timeout -> timeout_err, FAULT.
REQ-022 FAULT: no error pulses; cnt, last_period, pulse_count keep updating; clr_fault=1 -> ACQUIRE.
REQ-023 clr_fault outside FAULT SHALL be ignored.
REQ-024 clr_fault and clk_en_in in the same cycle: clear wins -> ACQUIRE; that pulse is not counted as the ACQUIRE first pulse but does update cnt, last_period, pulse_count.
REQ-025 All outputs SHALL be registered; locked/fault/error pulses/last_period SHALL update the cycle after the deciding clk_en_in or timeout cycle.
REQ-026 last_period SHALL update on every pulse except the first after reset.
REQ-027 pulse_count SHALL increment on every clk_en_in=1 cycle in all states.

Reset
REQ-028 rst=1 SHALL set state=ACQUIRE, cnt=0, good_cnt=0, locked=0, fault=0, window_err=0, timeout_err=0, last_period=0, pulse_count=0 at the next edge.
REQ-029 Reset mid-interval or mid-FAULT SHALL discard all history; no error pulse on exit from reset.
REQ-030 clk_en_in during rst=1 SHALL be ignored.

Structure
REQ-031 Shared package ce_mon_pkg SHALL hold the state enumeration and default PERIOD/TOL/LOCK_COUNT constants.
REQ-032 Interval counter with saturation and timeout detect SHALL be sub-module ce_interval_counter; FSM and outputs in top.
REQ-033 No derived clocks; single clock domain.

Verification (PERIOD=16, TOL=1, LOCK_COUNT=3)
REQ-034 Pulses every 16 cycles -> locked=1 one cycle after the 4th pulse; last_period=16; no errors.
REQ-035 Locked, next pulse after 12 cycles -> window_err one pulse, fault=1, locked=0, last_period=12.
REQ-036 Locked, pulses stop -> timeout_err once when cnt+1=17, fault=1, cnt holds; no further timeout_err.
REQ-037 FAULT, clr_fault with clk_en_in same cycle -> ACQUIRE; lock needs 3 more in-window intervals after the next pulse.
REQ-038 LOCKING with 2 good intervals, then interval 15, 17, 18 -> 15 and 17 accepted, locked=1; an 18 gap triggers timeout at 17 instead.
REQ-039 rst=1 mid-interval while LOCKED -> all outputs 0, pulse_count=0, next pulse treated as first.
